// File: rtl/sdr_pkg.sv
// Shared types and helpers for the serial demux router.
// Holds the FSM state enum and the channel-field width helper.
package sdr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_STOP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // ceil(log2(n)), never below 1 so a channel field always exists
    function automatic int ch_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sdr_counter.sv
// Loadable down-counter with zero flag.
// Ports: clk, rst (async high), i_load/i_val load, i_dec decrement,
// o_count current value, o_zero set when o_count is 0.
module sdr_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_val;
        end else if (i_dec) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/serial_demux_router.sv
// Serial frame receiver routing the payload to one of NCH outputs.
// Frame: start(0), header {ch, len} MSB-first, len payload bits, stop(1).
// Ports: clk, rst (async high), sin serial in, ch_en channel enables,
// dout/dvalid routed payload, busy/done/drop/error status,
// cur_ch/cur_len latched channel and remaining payload bits.
module serial_demux_router
    import sdr_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int LEN_W = 6,
    localparam int CH_W  = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   dout,
    output logic [NCH-1:0]   dvalid,
    output logic             busy,
    output logic             done,
    output logic             drop,
    output logic             error,
    output logic [CH_W-1:0]  cur_ch,
    output logic [LEN_W-1:0] cur_len
);

    localparam int HDR_BITS = CH_W + LEN_W;
    localparam int HC_W     = ch_w(HDR_BITS);

    state_t r_state;
    state_t w_next;

    logic [HDR_BITS-2:0] r_hdr;
    logic [CH_W-1:0]     r_ch;
    logic                r_en;

    logic [HDR_BITS-1:0] w_hdr;
    logic [CH_W-1:0]     w_hdr_ch;
    logic [LEN_W-1:0]    w_hdr_len;
    logic                w_start;
    logic                w_in_hdr;
    logic                w_in_pay;
    logic                w_hdr_last;
    logic                w_pay_on;
    logic [HC_W-1:0]     w_hc_count;
    logic                w_hc_zero;
    logic [LEN_W-1:0]    w_len;
    logic                w_len_zero_unused;

    // Complete header including the bit on the line this cycle
    assign w_hdr     = {r_hdr, sin};
    assign w_hdr_ch  = w_hdr[HDR_BITS-1 -: CH_W];
    assign w_hdr_len = w_hdr[LEN_W-1:0];

    assign w_start    = (r_state == ST_IDLE) && !sin;
    assign w_in_hdr   = (r_state == ST_HDR);
    assign w_in_pay   = (r_state == ST_PAY);
    assign w_hdr_last = w_in_hdr && w_hc_zero;

    // Counts remaining header bits; zero marks the last header cycle
    sdr_counter #(
        .W (HC_W)
    ) u_hdr_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start),
        .i_val   (HC_W'(HDR_BITS - 1)),
        .i_dec   (w_in_hdr && !w_hc_zero),
        .o_count (w_hc_count),
        .o_zero  (w_hc_zero)
    );

    // Remaining payload bits, including the one on the line
    sdr_counter #(
        .W (LEN_W)
    ) u_len_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hdr_last),
        .i_val   (w_hdr_len),
        .i_dec   (w_in_pay),
        .o_count (w_len),
        .o_zero  (w_len_zero_unused)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!sin) w_next = ST_HDR;
            end
            ST_HDR: begin
                if (w_hc_zero) begin
                    w_next = (w_hdr_len == '0) ? ST_STOP : ST_PAY;
                end
            end
            ST_PAY: begin
                if (w_len == LEN_W'(1)) w_next = ST_STOP;
            end
            ST_STOP: begin
                w_next = sin ? ST_IDLE : ST_ERR;
            end
            ST_ERR: begin
                if (sin) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hdr   <= '0;
            r_ch    <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_hdr) begin
                r_hdr <= w_hdr[HDR_BITS-2:0];
            end
            // ch_en only matters at the last header bit
            if (w_hdr_last) begin
                r_ch <= w_hdr_ch;
                r_en <= ch_en[w_hdr_ch];
            end
        end
    end

    assign w_pay_on = w_in_pay && r_en;
    assign dvalid   = w_pay_on ? (NCH'(1) << r_ch) : '0;
    assign dout     = dvalid & {NCH{sin}};
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_STOP) && sin;
    assign drop     = done && !r_en;
    assign error    = (r_state == ST_ERR);
    assign cur_ch   = r_ch;
    assign cur_len  = w_len;

endmodule

// File: tb/tb_serial_demux_router.sv
// Self-checking bench for serial_demux_router (NCH=4, LEN_W=6).
// Directed scenarios followed by randomized frames vs a frame-level model.
module tb_serial_demux_router;

    logic       clk;
    logic       rst;
    logic       sin;
    logic [3:0] ch_en;
    logic [3:0] dout;
    logic [3:0] dvalid;
    logic       busy;
    logic       done;
    logic       drop;
    logic       error;
    logic [1:0] cur_ch;
    logic [5:0] cur_len;

    int vectors;
    int miscompares;

    serial_demux_router #(
        .NCH   (4),
        .LEN_W (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .ch_en   (ch_en),
        .dout    (dout),
        .dvalid  (dvalid),
        .busy    (busy),
        .done    (done),
        .drop    (drop),
        .error   (error),
        .cur_ch  (cur_ch),
        .cur_len (cur_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, check outputs, advance past the edge.
    // e_ch / e_len < 0 skip that check.
    task automatic step(input logic s, input logic [3:0] en,
                        input logic [3:0] e_dv, input logic [3:0] e_do,
                        input logic e_busy, input logic e_done,
                        input logic e_drop, input logic e_err,
                        input int e_ch, input int e_len);
        sin   = s;
        ch_en = en;
        #1;
        chk("dvalid", 32'(dvalid), 32'(e_dv));
        chk("dout",   32'(dout),   32'(e_do));
        chk("busy",   32'(busy),   32'(e_busy));
        chk("done",   32'(done),   32'(e_done));
        chk("drop",   32'(drop),   32'(e_drop));
        chk("error",  32'(error),  32'(e_err));
        if (e_ch >= 0)  chk("cur_ch",  32'(cur_ch),  32'(e_ch));
        if (e_len >= 0) chk("cur_len", 32'(cur_len), 32'(e_len));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int e_ch, input int e_len);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                 e_ch, e_len);
        end
    endtask

    // One full frame. Expected outputs follow from the frame definition:
    // channel enable is the en value present on the last header bit;
    // abort_at >= 0 asserts rst on that payload index instead of finishing.
    task automatic frame(input int ch, input int len,
                         input logic [63:0] pay, input logic stp,
                         input logic [3:0] en, input int nerr,
                         input int abort_at);
        logic [7:0] hdr;
        logic [3:0] dv;
        logic       on;
        hdr = {2'(ch), 6'(len)};
        on  = en[ch];
        dv  = on ? (4'b0001 << ch) : 4'b0000;
        step(1'b0, 4'($urandom), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        for (int i = 7; i >= 0; i--) begin
            step(hdr[i], (i == 0) ? en : 4'($urandom),
                 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        end
        for (int k = 0; k < len; k++) begin
            if (k == abort_at) begin
                sin   = pay[k];
                ch_en = 4'($urandom);
                rst   = 1'b1;
                #1;
                chk("rst_dvalid",  32'(dvalid),  0);
                chk("rst_dout",    32'(dout),    0);
                chk("rst_busy",    32'(busy),    0);
                chk("rst_done",    32'(done),    0);
                chk("rst_drop",    32'(drop),    0);
                chk("rst_error",   32'(error),   0);
                chk("rst_cur_ch",  32'(cur_ch),  0);
                chk("rst_cur_len", 32'(cur_len), 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                idle(2, 0, 0);
                return;
            end
            step(pay[k], 4'($urandom), dv, pay[k] ? dv : 4'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, ch, len - k);
        end
        step(stp, 4'($urandom), 4'h0, 4'h0, 1'b1, stp, stp && !on, 1'b0,
             ch, 0);
        if (!stp) begin
            for (int j = 0; j < nerr; j++) begin
                step(1'b0, 4'($urandom), 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1,
                     ch, 0);
            end
            step(1'b1, 4'($urandom), 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1,
                 ch, 0);
        end
        idle(1, ch, 0);
    endtask

    initial begin
        int        r_ch;
        int        r_len;
        logic [63:0] r_pay;
        logic      r_stp;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        sin   = 1'b1;
        ch_en = 4'h0;
        #1;
        chk("reset_busy",    32'(busy),    0);
        chk("reset_dvalid",  32'(dvalid),  0);
        chk("reset_cur_ch",  32'(cur_ch),  0);
        chk("reset_cur_len", 32'(cur_len), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // a) idle line after reset
        idle(20, 0, 0);
        // b) channel 2, length 3, payload 1,0,1
        frame(2, 3, 64'b101, 1'b1, 4'hF, 0, -1);
        // c) channel 1, length 0
        frame(1, 0, 64'h0, 1'b1, 4'hF, 0, -1);
        // d) length 2, bad stop, 3 more zeros
        frame(0, 2, 64'b10, 1'b0, 4'hF, 3, -1);
        // e) disabled channel 3
        frame(3, 2, 64'b11, 1'b1, 4'b0111, 0, -1);
        // f) reset on 2nd payload cycle, then a good frame
        frame(1, 5, 64'b10111, 1'b1, 4'hF, 0, 1);
        frame(2, 3, 64'b101, 1'b1, 4'hF, 0, -1);

        for (int n = 0; n < 40; n++) begin
            r_ch  = int'($urandom_range(0, 3));
            r_len = int'($urandom_range(0, 12));
            r_pay = {$urandom, $urandom};
            r_stp = ($urandom_range(0, 3) != 0);
            frame(r_ch, r_len, r_pay, r_stp, 4'($urandom),
                  int'($urandom_range(0, 3)), -1);
            idle(int'($urandom_range(0, 3)), r_ch, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
